// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction-decode stage of the 5-stage MIPS-lite pipeline.
//
// Takes the IF/ID buffer (pc + 32-bit instruction), decodes it, reads the
// 32x32 register file (with write-through from WB), and registers the result
// into the ID/EX buffer together with the forwarding selects for both source
// operands. Load-use hazards stall IF for exactly one cycle; a branch flush
// from EX squashes the instruction in ID; HALT parks the stage until reset.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   if_valid, if_pc, if_instr  IF/ID buffer
//   flush                      branch taken in EX, squash ID this cycle
//   wb_we, wb_rd, wb_data      register-file write port from WB
//   stall                      combinational, hold PC and IF/ID buffer
//   id_*                       registered ID/EX buffer (id_valid=0 -> bubble)
//   fwd_a, fwd_b               operand source: 00 RF, 01 EX/MEM, 10 MEM/WB
//   halted                     HALT has issued; stage idle until reset
//
// Handshake: the IF/ID entry is consumed at a rising edge when if_valid=1 and
// stall=0. flush or halted discards the entry without stalling. Every edge
// loads the ID/EX buffer, with a bubble whenever nothing was consumed.
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int DATA           = 32,
    parameter int ADDRESSWIDTH   = 32,
    parameter int REGISTERNUMBER = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_valid,
    input  logic [ADDRESSWIDTH-1:0] if_pc,
    input  logic [31:0]             if_instr,
    input  logic                    flush,
    input  logic                    wb_we,
    input  logic [4:0]              wb_rd,
    input  logic [DATA-1:0]         wb_data,
    output logic                    stall,
    output logic                    id_valid,
    output logic [ADDRESSWIDTH-1:0] id_pc,
    output logic [5:0]              id_opcode,
    output logic [4:0]              id_rs,
    output logic [4:0]              id_rt,
    output logic [4:0]              id_dest,
    output logic [DATA-1:0]         id_rs_val,
    output logic [DATA-1:0]         id_rt_val,
    output logic [DATA-1:0]         id_imm,
    output logic                    id_reg_we,
    output logic                    id_mem_we,
    output logic                    id_load,
    output logic                    id_use_imm,
    output logic                    id_branch,
    output logic                    id_jump,
    output logic                    id_halt,
    output logic [1:0]              fwd_a,
    output logic [1:0]              fwd_b,
    output logic                    halted
);

    // Opcodes
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_SUBI = 6'h03;
    localparam logic [5:0] OP_MUL  = 6'h04;
    localparam logic [5:0] OP_MULI = 6'h05;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_ORI  = 6'h07;
    localparam logic [5:0] OP_AND  = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_XOR  = 6'h0A;
    localparam logic [5:0] OP_XORI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // -------------------------------------------------------------------------
    // Field extraction
    // -------------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm16;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign imm16  = if_instr[15:0];

    // -------------------------------------------------------------------------
    // Control decode. Unknown opcodes fall through to a NOP: still a valid
    // entry, but every control bit stays 0.
    // -------------------------------------------------------------------------
    logic dec_reg_we, dec_mem_we, dec_load, dec_use_imm;
    logic dec_branch, dec_jump, dec_halt, dec_rtype;
    logic reads_rs, reads_rt;
    logic [4:0] dec_dest;

    always_comb begin
        dec_reg_we  = 1'b0;
        dec_mem_we  = 1'b0;
        dec_load    = 1'b0;
        dec_use_imm = 1'b0;
        dec_branch  = 1'b0;
        dec_jump    = 1'b0;
        dec_halt    = 1'b0;
        dec_rtype   = 1'b0;
        reads_rs    = 1'b0;
        reads_rt    = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
                dec_reg_we = 1'b1;
                dec_rtype  = 1'b1;
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
                dec_reg_we  = 1'b1;
                dec_use_imm = 1'b1;
                reads_rs    = 1'b1;
            end
            OP_LDW: begin
                dec_reg_we  = 1'b1;
                dec_load    = 1'b1;
                dec_use_imm = 1'b1;
                reads_rs    = 1'b1;
            end
            OP_STW: begin
                dec_mem_we  = 1'b1;
                dec_use_imm = 1'b1;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
            end
            OP_BZ: begin
                dec_branch = 1'b1;
                reads_rs   = 1'b1;
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
            end
            OP_JR: begin
                dec_jump = 1'b1;
                reads_rs = 1'b1;
            end
            OP_HALT: begin
                dec_halt = 1'b1;
            end
            default: ;
        endcase
    end

    // R-type writes rd; everything else names its target in rt.
    assign dec_dest = dec_rtype ? rd : rt;

    // -------------------------------------------------------------------------
    // Register file with write-through: a same-cycle WB write to the register
    // being read is returned directly so WB and ID never race.
    // -------------------------------------------------------------------------
    logic [DATA-1:0] rf_q [0:REGISTERNUMBER-1];
    logic [DATA-1:0] rs_val, rt_val;

    assign rs_val = (rs == 5'd0) ? '0 :
                    (wb_we && (wb_rd == rs)) ? wb_data : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 :
                    (wb_we && (wb_rd == rt)) ? wb_data : rf_q[rt];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGISTERNUMBER; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Producer tracker. The EX slot is the ID/EX buffer itself; the MEM slot
    // is a one-cycle-delayed copy of the fields that matter for hazards.
    // -------------------------------------------------------------------------
    logic       id_valid_q, id_reg_we_q, id_load_q;
    logic [4:0] id_dest_q;
    logic       mem_valid_q, mem_reg_we_q;
    logic [4:0] mem_dest_q;
    logic       halted_q;

    // -------------------------------------------------------------------------
    // Hazard detection. r0 never matches because a load to r0 is excluded
    // and forwarding lookups are skipped for source index 0.
    // -------------------------------------------------------------------------
    logic load_use, accept, issue;

    assign load_use = id_valid_q && id_load_q && (id_dest_q != 5'd0) &&
                      ((reads_rs && (rs == id_dest_q)) ||
                       (reads_rt && (rt == id_dest_q)));

    // flush and halted win over stall: the entry is dropped, not held.
    assign accept = if_valid && !flush && !halted_q;
    assign stall  = accept && load_use;
    assign issue  = accept && !load_use;

    // Forwarding select for one source operand. A load sitting in EX cannot
    // supply data yet; that case is covered by the stall, after which the
    // load has moved to MEM and the MEM/WB path is picked instead.
    function automatic logic [1:0] fwd_sel(input logic       reads,
                                           input logic [4:0] src,
                                           input logic       ex_v,
                                           input logic       ex_we,
                                           input logic       ex_ld,
                                           input logic [4:0] ex_dst,
                                           input logic       mem_v,
                                           input logic       mem_we,
                                           input logic [4:0] mem_dst);
        logic [1:0] sel;
        sel = FWD_RF;
        if (reads && (src != 5'd0)) begin
            if (ex_v && ex_we && !ex_ld && (ex_dst == src)) begin
                sel = FWD_EX;
            end else if (mem_v && mem_we && (mem_dst == src)) begin
                sel = FWD_MEM;
            end
        end
        return sel;
    endfunction

    logic [1:0] fwd_a_sel, fwd_b_sel;

    assign fwd_a_sel = fwd_sel(reads_rs, rs, id_valid_q, id_reg_we_q, id_load_q,
                               id_dest_q, mem_valid_q, mem_reg_we_q, mem_dest_q);
    assign fwd_b_sel = fwd_sel(reads_rt, rt, id_valid_q, id_reg_we_q, id_load_q,
                               id_dest_q, mem_valid_q, mem_reg_we_q, mem_dest_q);

    // -------------------------------------------------------------------------
    // ID/EX next state: either the decoded instruction or an all-zero bubble.
    // -------------------------------------------------------------------------
    logic                    id_valid_d, id_reg_we_d, id_load_d;
    logic [ADDRESSWIDTH-1:0] id_pc_d, id_pc_q;
    logic [5:0]              id_opcode_d, id_opcode_q;
    logic [4:0]              id_rs_d, id_rs_q, id_rt_d, id_rt_q, id_dest_d;
    logic [DATA-1:0]         id_rs_val_d, id_rs_val_q, id_rt_val_d, id_rt_val_q;
    logic [DATA-1:0]         id_imm_d, id_imm_q;
    logic                    id_mem_we_d, id_mem_we_q, id_use_imm_d, id_use_imm_q;
    logic                    id_branch_d, id_branch_q, id_jump_d, id_jump_q;
    logic                    id_halt_d, id_halt_q;
    logic [1:0]              fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
    logic                    halted_d;

    always_comb begin
        id_valid_d   = 1'b0;
        id_pc_d      = '0;
        id_opcode_d  = '0;
        id_rs_d      = '0;
        id_rt_d      = '0;
        id_dest_d    = '0;
        id_rs_val_d  = '0;
        id_rt_val_d  = '0;
        id_imm_d     = '0;
        id_reg_we_d  = 1'b0;
        id_mem_we_d  = 1'b0;
        id_load_d    = 1'b0;
        id_use_imm_d = 1'b0;
        id_branch_d  = 1'b0;
        id_jump_d    = 1'b0;
        id_halt_d    = 1'b0;
        fwd_a_d      = FWD_RF;
        fwd_b_d      = FWD_RF;
        halted_d     = halted_q;
        if (issue) begin
            id_valid_d   = 1'b1;
            id_pc_d      = if_pc;
            id_opcode_d  = opcode;
            id_rs_d      = rs;
            id_rt_d      = rt;
            id_dest_d    = dec_dest;
            id_rs_val_d  = rs_val;
            id_rt_val_d  = rt_val;
            id_imm_d     = {{(DATA-16){imm16[15]}}, imm16};
            id_reg_we_d  = dec_reg_we;
            id_mem_we_d  = dec_mem_we;
            id_load_d    = dec_load;
            id_use_imm_d = dec_use_imm;
            id_branch_d  = dec_branch;
            id_jump_d    = dec_jump;
            id_halt_d    = dec_halt;
            fwd_a_d      = fwd_a_sel;
            fwd_b_d      = fwd_b_sel;
            halted_d     = halted_q | dec_halt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_opcode_q  <= '0;
            id_rs_q      <= '0;
            id_rt_q      <= '0;
            id_dest_q    <= '0;
            id_rs_val_q  <= '0;
            id_rt_val_q  <= '0;
            id_imm_q     <= '0;
            id_reg_we_q  <= 1'b0;
            id_mem_we_q  <= 1'b0;
            id_load_q    <= 1'b0;
            id_use_imm_q <= 1'b0;
            id_branch_q  <= 1'b0;
            id_jump_q    <= 1'b0;
            id_halt_q    <= 1'b0;
            fwd_a_q      <= FWD_RF;
            fwd_b_q      <= FWD_RF;
            mem_valid_q  <= 1'b0;
            mem_reg_we_q <= 1'b0;
            mem_dest_q   <= '0;
            halted_q     <= 1'b0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_opcode_q  <= id_opcode_d;
            id_rs_q      <= id_rs_d;
            id_rt_q      <= id_rt_d;
            id_dest_q    <= id_dest_d;
            id_rs_val_q  <= id_rs_val_d;
            id_rt_val_q  <= id_rt_val_d;
            id_imm_q     <= id_imm_d;
            id_reg_we_q  <= id_reg_we_d;
            id_mem_we_q  <= id_mem_we_d;
            id_load_q    <= id_load_d;
            id_use_imm_q <= id_use_imm_d;
            id_branch_q  <= id_branch_d;
            id_jump_q    <= id_jump_d;
            id_halt_q    <= id_halt_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            // EX slot moves to MEM every cycle, bubbles included.
            mem_valid_q  <= id_valid_q;
            mem_reg_we_q <= id_reg_we_q;
            mem_dest_q   <= id_dest_q;
            halted_q     <= halted_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign id_opcode  = id_opcode_q;
    assign id_rs      = id_rs_q;
    assign id_rt      = id_rt_q;
    assign id_dest    = id_dest_q;
    assign id_rs_val  = id_rs_val_q;
    assign id_rt_val  = id_rt_val_q;
    assign id_imm     = id_imm_q;
    assign id_reg_we  = id_reg_we_q;
    assign id_mem_we  = id_mem_we_q;
    assign id_load    = id_load_q;
    assign id_use_imm = id_use_imm_q;
    assign id_branch  = id_branch_q;
    assign id_jump    = id_jump_q;
    assign id_halt    = id_halt_q;
    assign fwd_a      = fwd_a_q;
    assign fwd_b      = fwd_b_q;
    assign halted     = halted_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS-lite pipeline.
- Consumes the IF/ID buffer (pc, 32-bit instruction) and holds the 32x32 register file.
- Produces the registered ID/EX buffer: operands, sign-extended immediate, control bits and forwarding selects.
- Detects load-use hazards and stalls IF; accepts branch flushes from EX; latches HALT.

Parameters:
- DATA, 32, register/operand width
- ADDRESSWIDTH, 32, PC width
- REGISTERNUMBER, 32, register count; index width = clog2 = 5

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- if_valid  in  1  IF/ID buffer holds a real instruction
- if_pc  in  ADDRESSWIDTH  PC of the instruction
- if_instr  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
- flush  in  1  branch taken in EX; squash the ID instruction this cycle
- wb_we  in  1  WB register write enable
- wb_rd  in  5  WB destination register
- wb_data  in  DATA  WB write data
- stall  out  1  combinational; hold PC and IF/ID buffer
- id_valid  out  1  ID/EX entry valid (0 = bubble)
- id_pc  out  ADDRESSWIDTH  PC of the decoded instruction
- id_opcode  out  6  opcode
- id_rs, id_rt  out  5 each  source register indices
- id_dest  out  5  destination register: rd for R-type, rt for I-type
- id_rs_val, id_rt_val  out  DATA each  register-file read values
- id_imm  out  DATA  sign-extended imm[15:0]
- id_reg_we, id_mem_we, id_load, id_use_imm, id_branch, id_jump, id_halt  out  1 each  control bits
- fwd_a, fwd_b  out  2 each  operand source: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB data
- halted  out  1  HALT has issued; stage idle until reset

Behaviour:
- Reset: all id_* outputs are 0, fwd_a/fwd_b are 00, halted is 0, every register file entry is 0, both tracker slots are invalid.
- Opcodes:
  - R-type ALU (reg_we, reads rs and rt): ADD 00, SUB 02, MUL 04, OR 06, AND 08, XOR 0A.
  - I-type ALU (reg_we, use_imm, reads rs): ADDI 01, SUBI 03, MULI 05, ORI 07, ANDI 09, XORI 0B.
  - LDW 0C: reg_we, load, use_imm, reads rs.
  - STW 0D: mem_we, use_imm, reads rs and rt.
  - BZ 0E: branch, reads rs.
  - BEQ 0F: branch, reads rs and rt.
  - JR 10: jump, reads rs.
  - HALT 11: halt, reads nothing.
  - Any other opcode decodes as a NOP: valid, all control bits 0.
- r0 is hardwired to 0. Writes to r0 are ignored, r0 reads return 0, and r0 never creates a hazard or forward.
- Latency: one cycle. An instruction accepted at edge N appears on id_* after edge N.
- Register file:
  - Written at the clock edge when wb_we=1 and wb_rd != 0.
  - Same-cycle read of wb_rd returns wb_data (write-through bypass).
- Tracker slots:
  - EX slot is the current id_* output (valid, dest, reg_we, load).
  - MEM slot is the EX slot delayed by one cycle.
  - Both slots shift every cycle; bubbles shift in as invalid.
- Forwarding, per read source (rs → fwd_a, rt → fwd_b):
  - Match in EX slot with reg_we=1 and load=0 → 01.
  - Otherwise, match in MEM slot with reg_we=1 → 10.
  - Otherwise → 00.
  - EX slot has priority over MEM slot.
  - fwd_a/fwd_b are registered together with the instruction.
- Load-use stall:
  - stall=1 when if_valid=1, the EX slot is a valid load with dest != 0, and dest equals a source the instruction reads.
  - During a stall: bubble issued (id_valid=0, all control bits 0), IF/ID held.
  - Next cycle the load is in the MEM slot, so the dependent instruction issues with fwd=10. Exactly one stall cycle per load-use.
- Flush:
  - A bubble is issued and stall is forced to 0.
  - Flush has priority over stall and over HALT decode.
  - The tracker is unaffected apart from the bubble.
- Halt:
  - A valid, unflushed, unstalled HALT issues with id_halt=1; halted is set at the same edge.
  - While halted=1, only bubbles issue and stall=0.
  - Only reset clears halted.
- Reset mid-operation: all state clears immediately (asynchronous) and the in-flight entry is discarded.

Test Plan:
- ADDI r1,r0,5 then ADD r2,r1,r1 back-to-back → second instruction issues with fwd_a=01 and fwd_b=01, no stall; id_imm=0x00000005.
- LDW r3,0(r0) then SUB r4,r3,r0 → stall=1 for exactly one cycle with id_valid=0; SUB then issues with fwd_a=10.
- wb_we=1, wb_rd=7, wb_data=0xDEADBEEF while ID decodes XOR r8,r7,r7 → id_rs_val=id_rt_val=0xDEADBEEF with fwd_a=fwd_b=00; same stimulus with wb_rd=0 → id_rs_val=0 if r7=0.
- ORI r5,r5,0xFFFF → id_imm=0xFFFFFFFF, id_dest=5, id_use_imm=1; BEQ r0,r0 after ADD r0,… → no forward and no stall.
- flush=1 coincident with a pending HALT → bubble issued, halted stays 0; next cycle HALT issues → id_halt=1 and halted=1, later instructions become bubbles.
- Assert reset mid-stream during a stall → all outputs 0 and stall=0 immediately; register file reads 0 after release.
